// File: rtl/instruction_decode_pkg.sv
// Shared decode-stage constants: opcodes, field positions, register sizing.
package instruction_decode_pkg;

  localparam int REG_IDX_W    = 5;
  localparam int NUM_REGS     = 32;
  localparam int LINK_REG_DEF = 31;

  localparam int OP_LSB  = 26;
  localparam int OP_W    = 6;
  localparam int RS_LSB  = 21;
  localparam int RT_LSB  = 16;
  localparam int RD_LSB  = 11;
  localparam int IMM_LSB = 0;
  localparam int IMM_W   = 16;

  localparam logic [OP_W-1:0] OP_ANDI = 6'h0C;
  localparam logic [OP_W-1:0] OP_ORI  = 6'h0D;
  localparam logic [OP_W-1:0] OP_XORI = 6'h0E;

endpackage

// File: rtl/register_file.sv
// 32-entry register file: two async reads, one sync write,
// async active-low clear, register 0 hard-wired to zero.
module register_file
  import instruction_decode_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [REG_IDX_W-1:0]  wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [REG_IDX_W-1:0]  rd_addr_1,
  input  logic [REG_IDX_W-1:0]  rd_addr_2,
  output logic [DATA_WIDTH-1:0] rd_data_1,
  output logic [DATA_WIDTH-1:0] rd_data_2
);

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_en && (wr_addr != '0)) begin
      regs[wr_addr] <= wr_data;
    end
  end

  // No bypass: a same-cycle write is seen only after the edge.
  assign rd_data_1 = (rd_addr_1 == '0) ? '0 : regs[rd_addr_1];
  assign rd_data_2 = (rd_addr_2 == '0) ? '0 : regs[rd_addr_2];

endmodule

// File: rtl/instruction_decode.sv
// MIPS decode stage: field extraction, write-back muxes,
// immediate extender, and the register file.
module instruction_decode
  import instruction_decode_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int LINK_REG   = LINK_REG_DEF
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [31:0]           Instruction,
  input  logic [DATA_WIDTH-1:0] opcplus4,
  input  logic [DATA_WIDTH-1:0] ALU_result,
  input  logic [DATA_WIDTH-1:0] Mem_data,
  input  logic                  RegWrite,
  input  logic                  RegDst,
  input  logic                  MemtoReg,
  input  logic                  Jal,
  output logic [DATA_WIDTH-1:0] Read_data_1,
  output logic [DATA_WIDTH-1:0] Read_data_2,
  output logic [DATA_WIDTH-1:0] Sign_extend
);

  logic [OP_W-1:0]       opcode;
  logic [REG_IDX_W-1:0]  rs;
  logic [REG_IDX_W-1:0]  rt;
  logic [REG_IDX_W-1:0]  rd;
  logic [IMM_W-1:0]      imm;
  logic [REG_IDX_W-1:0]  wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_en;
  logic                  zext;

  assign opcode = Instruction[OP_LSB +: OP_W];
  assign rs     = Instruction[RS_LSB +: REG_IDX_W];
  assign rt     = Instruction[RT_LSB +: REG_IDX_W];
  assign rd     = Instruction[RD_LSB +: REG_IDX_W];
  assign imm    = Instruction[IMM_LSB +: IMM_W];

  always_comb begin
    wr_addr = rt;
    if (Jal) begin
      wr_addr = REG_IDX_W'(LINK_REG);
    end else if (RegDst) begin
      wr_addr = rd;
    end
  end

  always_comb begin
    wr_data = ALU_result;
    if (Jal) begin
      wr_data = opcplus4;
    end else if (MemtoReg) begin
      wr_data = Mem_data;
    end
  end

  assign wr_en = RegWrite | Jal;

  // Logical immediates are zero-extended; everything else sign-extends.
  always_comb begin
    zext = 1'b0;
    unique case (opcode)
      OP_ANDI, OP_ORI, OP_XORI: zext = 1'b1;
      default:                  zext = 1'b0;
    endcase
  end

  assign Sign_extend = zext
    ? {{(DATA_WIDTH-IMM_W){1'b0}}, imm}
    : {{(DATA_WIDTH-IMM_W){imm[IMM_W-1]}}, imm};

  register_file #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_register_file (
    .clock    (clock),
    .reset    (reset),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rd_addr_1(rs),
    .rd_addr_2(rt),
    .rd_data_1(Read_data_1),
    .rd_data_2(Read_data_2)
  );

endmodule
